// File: rtl/phy_pkg.sv
// Shared PHY receive-side definitions: symbol constants, defaults and FSM encoding.
package phy_pkg;

    localparam int         PHY_WIDTH     = 8;
    localparam logic [7:0] PHY_COM       = 8'hBC;
    localparam int         PHY_COM_COUNT = 4;

    typedef logic [1:0] phy_state_t;

    localparam phy_state_t UNSYNC = 2'd0;
    localparam phy_state_t ALIGN  = 2'd1;
    localparam phy_state_t ACTIVE = 2'd2;

endpackage

// File: rtl/serial_paralelo_rx.sv
// Single-lane serial-to-parallel receiver with COM-symbol byte alignment.
//
// state  | meaning
// -------+-------------------------------------------------------------
// UNSYNC | sliding search for COM on every bit
// ALIGN  | byte lock tentative, counting consecutive aligned COMs
// ACTIVE | synchronized, non-COM bytes delivered with a valid strobe
module serial_paralelo_rx
    import phy_pkg::*;
#(
    parameter int               WIDTH     = PHY_WIDTH,
    parameter logic [WIDTH-1:0] COM       = WIDTH'(PHY_COM),
    parameter int               COM_COUNT = PHY_COM_COUNT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             active
);

    localparam int              CW         = $clog2(WIDTH);
    localparam logic [CW-1:0]   BIT_LAST   = CW'(WIDTH - 1);
    localparam logic [3:0]      COM_TARGET = 4'(COM_COUNT);

    phy_state_t       state;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    bit_cnt;
    logic [3:0]       com_cnt;

    logic [WIDTH-1:0] cand;
    logic             cand_is_com;
    logic             at_boundary;

    // Byte ending on the current bit and the boundary/COM qualifiers derived from it
    always_comb begin
        cand        = {sr[WIDTH-2:0], data_in};
        cand_is_com = (cand == COM);
        at_boundary = (bit_cnt == BIT_LAST);
    end

    // Serial shift register, MSB first
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr <= '0;
        end else if (!enable) begin
            sr <= '0;
        end else begin
            sr <= cand;
        end
    end

    // Alignment FSM with bit and COM counters; active mirrors ACTIVE as a register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= UNSYNC;
            bit_cnt <= '0;
            com_cnt <= '0;
            active  <= 1'b0;
        end else if (!enable) begin
            state   <= UNSYNC;
            bit_cnt <= '0;
            com_cnt <= '0;
            active  <= 1'b0;
        end else begin
            case (state)
                UNSYNC: begin
                    if (cand_is_com) begin
                        com_cnt <= 4'd1;
                        bit_cnt <= '0;
                        if (COM_COUNT == 1) begin
                            state  <= ACTIVE;
                            active <= 1'b1;
                        end else begin
                            state <= ALIGN;
                        end
                    end
                end
                ALIGN: begin
                    bit_cnt <= bit_cnt + 1'b1;
                    if (at_boundary) begin
                        if (cand_is_com) begin
                            com_cnt <= com_cnt + 4'd1;
                            if ((com_cnt + 4'd1) == COM_TARGET) begin
                                state  <= ACTIVE;
                                active <= 1'b1;
                            end
                        end else begin
                            // Lost alignment: the offending bits are not searched this cycle
                            state   <= UNSYNC;
                            com_cnt <= '0;
                            bit_cnt <= '0;
                        end
                    end
                end
                ACTIVE: begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
                default: begin
                    state   <= UNSYNC;
                    bit_cnt <= '0;
                    com_cnt <= '0;
                    active  <= 1'b0;
                end
            endcase
        end
    end

    // Parallel output: latch non-COM bytes on ACTIVE boundaries, one-cycle strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out  <= '0;
            valid_out <= 1'b0;
        end else if (!enable) begin
            data_out  <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            if (state == ACTIVE && at_boundary && !cand_is_com) begin
                data_out  <= cand;
                valid_out <= 1'b1;
            end
        end
    end

endmodule
